// File: rtl/dither_pixel_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dither_pixel_feeder_if : pixel request/response bus between feeder and source
// Revision 1.0
// ============================================================================
interface dither_pixel_feeder_if;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic        req_valid;
  logic [17:0] pixel_rgb;

  modport master (
    output req_x,
    output req_y,
    output req_valid,
    input  pixel_rgb
  );

  modport slave (
    input  req_x,
    input  req_y,
    input  req_valid,
    output pixel_rgb
  );
endinterface
`default_nettype wire

// File: rtl/dither_pixel_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dither_pixel_feeder : VGA timing, pixel fetch and coarse/remainder split
// Revision 1.0
// ============================================================================
module dither_pixel_feeder #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_pix_ce,
  dither_pixel_feeder_if.master  src,
  output logic [3:0]             o_cer,
  output logic [3:0]             o_ceg,
  output logic [3:0]             o_ceb,
  output logic [1:0]             o_rms,
  output logic [1:0]             o_gms,
  output logic [1:0]             o_bms,
  output logic                   o_hc,
  output logic                   o_vc,
  output logic                   o_hsync_n,
  output logic                   o_vsync_n,
  output logic                   o_blank,
  output logic                   o_frame_start
);

  localparam int         c_H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last   = 10'(c_H_TOT - 1);
  localparam logic [9:0] c_v_last   = 10'(c_V_TOT - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VIS);
  localparam logic [9:0] c_v_vis    = 10'(V_VIS);
  localparam logic [9:0] c_hs_beg   = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_beg   = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_visible;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_origin;

  logic        r_s1_hsync;
  logic        r_s1_vsync;
  logic        r_s1_blank;
  logic        r_s1_hc;
  logic        r_s1_vc;
  logic        r_s1_origin;

  logic        r_hsync_n;
  logic        r_vsync_n;
  logic        r_blank;
  logic        r_hc;
  logic        r_vc;
  logic        r_frame_start;
  logic [17:0] r_rgb;
  logic [17:0] w_rgb;

  assign w_h_wrap  = (r_hcnt == c_h_last);
  assign w_v_wrap  = (r_vcnt == c_v_last);
  assign w_visible = (r_hcnt < c_h_vis) && (r_vcnt < c_v_vis);
  assign w_hsync   = (r_hcnt >= c_hs_beg) && (r_hcnt < c_hs_end);
  assign w_vsync   = (r_vcnt >= c_vs_beg) && (r_vcnt < c_vs_end);
  assign w_origin  = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

  assign src.req_x     = r_hcnt;
  assign src.req_y     = r_vcnt;
  assign src.req_valid = w_visible;

  // Raster counters; vertical step shares the pix_ce of the horizontal wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else if (i_pix_ce) begin
      if (w_h_wrap) begin
        r_hcnt <= 10'd0;
        r_vcnt <= w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  // Stage 1: timing flags wait here while the source fetches the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_blank  <= 1'b1;
      r_s1_hc     <= 1'b0;
      r_s1_vc     <= 1'b0;
      r_s1_origin <= 1'b0;
    end else if (i_pix_ce) begin
      r_s1_hsync  <= w_hsync;
      r_s1_vsync  <= w_vsync;
      r_s1_blank  <= ~w_visible;
      r_s1_hc     <= r_hcnt[0];
      r_s1_vc     <= r_vcnt[0];
      r_s1_origin <= w_origin;
    end
  end

  assign w_rgb = r_s1_blank ? 18'd0 : src.pixel_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_blank       <= 1'b1;
      r_hc          <= 1'b0;
      r_vc          <= 1'b0;
      r_frame_start <= 1'b0;
      r_rgb         <= 18'd0;
    end else if (i_pix_ce) begin
      r_hsync_n     <= ~r_s1_hsync;
      r_vsync_n     <= ~r_s1_vsync;
      r_blank       <= r_s1_blank;
      r_hc          <= r_s1_hc;
      r_vc          <= r_s1_vc;
      r_frame_start <= r_s1_origin;
      r_rgb         <= w_rgb;
    end
  end

  // Each 6-bit channel splits into a 4-bit coarse value and a 2-bit remainder.
  assign o_cer         = r_rgb[17:14];
  assign o_rms         = r_rgb[13:12];
  assign o_ceg         = r_rgb[11:8];
  assign o_gms         = r_rgb[7:6];
  assign o_ceb         = r_rgb[5:2];
  assign o_bms         = r_rgb[1:0];
  assign o_hc          = r_hc;
  assign o_vc          = r_vc;
  assign o_hsync_n     = r_hsync_n;
  assign o_vsync_n     = r_vsync_n;
  assign o_blank       = r_blank;
  assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_dither_pixel_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dither_pixel_feeder : scoreboard bench for dither_pixel_feeder
// Revision 1.0
// ============================================================================
module tb_dither_pixel_feeder;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  // Short frame keeps a full vertical cycle affordable in simulation.
  localparam int V_VIS  = 6;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam logic [23:0] RST_EXP = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  logic [3:0] o_cer, o_ceg, o_ceb;
  logic [1:0] o_rms, o_gms, o_bms;
  logic o_hc, o_vc, o_hsync_n, o_vsync_n, o_blank, o_frame_start;
  logic [23:0] obs;

  logic [23:0] sb[$];
  int mx, my, pulses;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dither_pixel_feeder_if src_if ();

  dither_pixel_feeder #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_ce     (pix_ce),
    .src          (src_if),
    .o_cer        (o_cer),
    .o_ceg        (o_ceg),
    .o_ceb        (o_ceb),
    .o_rms        (o_rms),
    .o_gms        (o_gms),
    .o_bms        (o_bms),
    .o_hc         (o_hc),
    .o_vc         (o_vc),
    .o_hsync_n    (o_hsync_n),
    .o_vsync_n    (o_vsync_n),
    .o_blank      (o_blank),
    .o_frame_start(o_frame_start)
  );

  assign obs = {o_blank, o_hsync_n, o_vsync_n, o_hc, o_vc, o_frame_start,
                o_cer, o_rms, o_ceg, o_gms, o_ceb, o_bms};

  function automatic logic [17:0] src_pix(int x, int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = x[9:0];
    yv = y[9:0];
    if (x == 1 && y == 1) return {6'b101110, 6'b111111, 6'b000011};
    if (x >= H_VIS) return 18'h3FFFF;
    return {xv[5:0], yv[5:0] ^ xv[9:4], xv[5:0] + yv[5:0]};
  endfunction

  function automatic logic [23:0] exp_of(int x, int y);
    logic blank, hs, vs, fs;
    logic [17:0] rgb;
    blank = !(x < H_VIS && y < V_VIS);
    hs    = (x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SYNC);
    vs    = (y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SYNC);
    fs    = (x == 0) && (y == 0);
    rgb   = blank ? 18'h0 : src_pix(x, y);
    return {blank, !hs, !vs, x[0], y[0], fs, rgb};
  endfunction

  // Pixel source: answers a request one pix_ce later.
  always @(posedge clk) begin
    if (pix_ce) src_if.pixel_rgb <= src_pix(int'(src_if.req_x), int'(src_if.req_y));
  end

  // Scoreboard consumer: after every pix_ce edge, check counters and outputs.
  always @(posedge clk) begin : mon
    logic [23:0] e;
    logic        ev;
    if (rst_n && pix_ce) begin
      #1;
      ev = (mx < H_VIS) && (my < V_VIS);
      n_vec++;
      if (src_if.req_x !== 10'(mx) || src_if.req_y !== 10'(my) || src_if.req_valid !== ev) begin
        n_err++;
        $display("FAIL req: got x=%0d y=%0d v=%b, want x=%0d y=%0d v=%b",
                 src_if.req_x, src_if.req_y, src_if.req_valid, mx, my, ev);
      end
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: got output %h, want a queued entry", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL pixel_out at pulse %0d: got %h, want %h", pulses, obs, e);
        end
      end
    end
  end

  task automatic sb_reset();
    sb.delete();
    sb.push_back(RST_EXP);
    mx = 0;
    my = 0;
    pulses = 0;
  endtask

  task automatic drive(int n, int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_ce = 1'b1;
      sb.push_back(exp_of(mx, my));
      pulses++;
      if (mx == H_TOT - 1) begin
        mx = 0;
        my = (my == V_TOT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      if (gap > 1) begin
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pix_ce = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (obs !== RST_EXP || src_if.req_x !== 10'd0 || src_if.req_y !== 10'd0) begin
      n_err++;
      $display("FAIL reset_state: got out=%h x=%0d y=%0d, want out=%h x=0 y=0",
               obs, src_if.req_x, src_if.req_y, RST_EXP);
    end
    rst_n = 1'b1;
    sb_reset();
    drive(1, 4);
    n_vec++;
    if (o_frame_start !== 1'b0 || o_blank !== 1'b1) begin
      n_err++;
      $display("FAIL first_pulse: got fs=%b blank=%b, want fs=0 blank=1", o_frame_start, o_blank);
    end
    drive(1, 4);
    n_vec++;
    if (o_frame_start !== 1'b1 || o_blank !== 1'b0 || o_hc !== 1'b0 || o_vc !== 1'b0) begin
      n_err++;
      $display("FAIL first_frame_start: got fs=%b blank=%b hc=%b vc=%b, want 1 0 0 0",
               o_frame_start, o_blank, o_hc, o_vc);
    end
  endtask

  task automatic test_quant();
    drive(H_TOT + 1 + 2 - pulses, 1);
    n_vec++;
    if ({o_cer, o_rms, o_ceg, o_gms, o_ceb, o_bms} !== {4'hB, 2'b10, 4'hF, 2'b11, 4'h0, 2'b11}) begin
      n_err++;
      $display("FAIL quant_11: got R=%h/%b G=%h/%b B=%h/%b, want R=b/10 G=f/11 B=0/11",
               o_cer, o_rms, o_ceg, o_gms, o_ceb, o_bms);
    end
    n_vec++;
    if (o_hc !== 1'b1 || o_vc !== 1'b1 || o_blank !== 1'b0) begin
      n_err++;
      $display("FAIL parity_11: got hc=%b vc=%b blank=%b, want 1 1 0", o_hc, o_vc, o_blank);
    end
  endtask

  task automatic test_horizontal();
    int vis_cnt = 0, vis_bad = 0, hs_cnt = 0, hs_first = -1, leak = 0;
    drive(2 * H_TOT + 2 - pulses, 1);
    for (int k = 0; k < H_TOT; k++) begin
      if (o_blank === 1'b0) vis_cnt++;
      if ((o_blank === 1'b0) != (k < H_VIS)) vis_bad++;
      if (o_hsync_n === 1'b0) begin
        if (hs_first < 0) hs_first = k;
        hs_cnt++;
      end
      if (o_blank === 1'b1 && {o_cer, o_rms, o_ceg, o_gms, o_ceb, o_bms} !== 18'h0) leak++;
      drive(1, 1);
    end
    n_vec++;
    if (vis_cnt != H_VIS || vis_bad != 0) begin
      n_err++;
      $display("FAIL line_visible: got %0d visible (%0d misplaced), want %0d (0)", vis_cnt, vis_bad, H_VIS);
    end
    n_vec++;
    if (hs_cnt != H_SYNC || hs_first != H_VIS + H_FP) begin
      n_err++;
      $display("FAIL hsync: got width=%0d start=%0d, want width=%0d start=%0d",
               hs_cnt, hs_first, H_SYNC, H_VIS + H_FP);
    end
    n_vec++;
    if (leak != 0) begin
      n_err++;
      $display("FAIL blank_data: got %0d blanked pixels with data, want 0", leak);
    end
    n_vec++;
    if (o_blank !== 1'b0 || o_hc !== 1'b0 || o_vc !== 1'b1) begin
      n_err++;
      $display("FAIL line_period: got blank=%b hc=%b vc=%b, want 0 0 1", o_blank, o_hc, o_vc);
    end
  endtask

  task automatic test_vertical();
    int fs_cnt = 0, vs_cnt = 0, vs_first = -1;
    drive(FRAME + 2 - pulses, 1);
    n_vec++;
    if (o_frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL frame_wrap: got fs=%b, want 1", o_frame_start);
    end
    for (int k = 0; k < FRAME; k++) begin
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_vsync_n === 1'b0) begin
        if (vs_first < 0) vs_first = k;
        vs_cnt++;
      end
      drive(1, 1);
    end
    n_vec++;
    if (vs_cnt != V_SYNC * H_TOT || vs_first != (V_VIS + V_FP) * H_TOT) begin
      n_err++;
      $display("FAIL vsync: got width=%0d start=%0d, want width=%0d start=%0d",
               vs_cnt, vs_first, V_SYNC * H_TOT, (V_VIS + V_FP) * H_TOT);
    end
    n_vec++;
    if (fs_cnt != 1 || o_frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL frame_period: got %0d starts, fs_next=%b, want 1 and 1", fs_cnt, o_frame_start);
    end
  endtask

  task automatic test_stall_reset();
    logic [23:0] snap;
    int bad = 0;
    drive(5 * H_TOT + 300 - (my * H_TOT + mx), 1);
    n_vec++;
    if (src_if.req_x !== 10'd300 || src_if.req_y !== 10'd5) begin
      n_err++;
      $display("FAIL stall_pos: got x=%0d y=%0d, want 300 5", src_if.req_x, src_if.req_y);
    end
    snap = obs;
    repeat (50) begin
      @(negedge clk);
      if (obs !== snap || src_if.req_x !== 10'd300 || src_if.req_y !== 10'd5) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d changed samples, want 0", bad);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== RST_EXP || src_if.req_x !== 10'd0 || src_if.req_y !== 10'd0) begin
      n_err++;
      $display("FAIL async_reset: got out=%h x=%0d y=%0d, want out=%h x=0 y=0",
               obs, src_if.req_x, src_if.req_y, RST_EXP);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_reset();
    n_vec++;
    if (src_if.req_x !== 10'd0 || src_if.req_y !== 10'd0) begin
      n_err++;
      $display("FAIL restart_pos: got x=%0d y=%0d, want 0 0", src_if.req_x, src_if.req_y);
    end
    drive(20, 4);
  endtask

  initial begin
    src_if.pixel_rgb = 18'h0;
    test_reset();
    test_quant();
    test_horizontal();
    test_vertical();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dither_pixel_feeder.md
Name: dither_pixel_feeder

Overview:
- Drives the input side of the ordered-dithering stage and produces VGA 640x480@60 timing.
- Generates pixel coordinates and requests 18-bit RGB (6 bits per channel) from a pixel source.
- Splits each channel into a 4-bit coarse value and a 2-bit remainder. Outputs the per-pixel position parity (hc, vc) that the dithering stage needs, delayed so that everything is aligned with hsync_n, vsync_n and blank.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous reset, active-low
pix_ce  in  1  pixel-rate enable, one-cycle pulse (every 4th clk at 25 MHz)
req_x  out  10  requested pixel column (= hcnt)
req_y  out  10  requested pixel row (= vcnt)
req_valid  out  1  high when (req_x, req_y) is visible
pixel_rgb  in  18  source pixel {R[17:12], G[11:6], B[5:0]}, valid one pix_ce after the request
CER, CEG, CEB  out  4 each  coarse channel value (bits [5:2] of the channel)
rms, gms, bms  out  2 each  channel remainder (bits [1:0] of the channel)
hc  out  1  column parity of the output pixel (hcnt[0])
vc  out  1  row parity of the output pixel (vcnt[0])
hsync_n  out  1  horizontal sync, active-low
vsync_n  out  1  vertical sync, active-low
blank  out  1  high outside the visible area
frame_start  out  1  one-pix_ce-wide pulse, aligned with output pixel (0,0)

Behaviour:
- Counters
  - hcnt counts 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800).
  - vcnt counts 0..V_TOT-1 (525).
  - Both advance only on clk edges with pix_ce=1. hcnt wraps to 0 and increments vcnt. vcnt wraps to 0 when hcnt wraps at V_TOT-1.
  - pix_ce=0 freezes every register in the block. All outputs hold.
- Stage 0 (combinational from counters)
  - req_x=hcnt, req_y=vcnt.
  - req_valid = (hcnt<H_VIS) && (vcnt<V_VIS).
- Stage 1 (registered on pix_ce)
  - The following are delayed one stage: sync flags, blank, hcnt[0], vcnt[0], and the flag "hcnt==0 && vcnt==0".
  - hsync active when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751).
  - vsync active when V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC (490..491).
- Stage 2 / outputs (registered on pix_ce)
  - pixel_rgb is sampled, split and registered together with the stage-1 timing.
  - Total latency is 2 pix_ce pulses from a counter value to its outputs. The source's data for request N is sampled at pulse N+1, so all outputs for pixel N appear after pulse N+2.
- Quantisation
  - CER=R[5:2], rms=R[1:0]. G and B are split the same way.
  - No rounding and no saturation here; the dithering stage handles the 15 ceiling.
- Blanking
  - While the delayed blank=1, CE* and *ms are forced to 0 regardless of pixel_rgb.
  - hc and vc still track parity.
- frame_start is 1 for exactly one pix_ce period, on the pixel where the outputs correspond to (0,0).
- Reset values: hcnt=0, vcnt=0, hsync_n=1, vsync_n=1, blank=1, CE*=0, *ms=0, hc=0, vc=0, frame_start=0.
  - The pipeline valid flags are cleared, so the first two pix_ce pulses after reset output blank=1 and syncs inactive.
  - frame_start first asserts on the 2nd pix_ce after reset.
  - Reset asserted mid-frame returns everything to reset values immediately, asynchronously. Counting restarts from (0,0) at the first pix_ce after release.
- Simultaneous events: the hcnt wrap and the vcnt increment/wrap happen on the same pix_ce. No event is ever skipped or doubled.

Test Plan:
- Reset and first frame: hold rst_n=0, then release; pulse pix_ce every 4 clk. Expect all outputs at reset values during reset. frame_start=1 after the 2nd pix_ce, with blank=0, hc=0, vc=0.
- Horizontal timing: count pix_ce pulses over one line. Expect blank=0 for 640 pulses. Expect hsync_n=0 for exactly 96 pulses, starting 656 pulses after the line's first visible output. Line period is 800 pulses.
- Vertical timing and wrap: run a full frame. Expect vsync_n=0 for 2 lines (1600 pulses) at lines 490..491. Frame period is 420000 pulses. frame_start recurs exactly once per frame.
- Quantisation and alignment: the source returns pixel_rgb = {6'b101110, 6'b111111, 6'b000011} for request (1,1). Expect at that output pixel: CER=4'hB, rms=2'b10; CEG=4'hF, gms=2'b11; CEB=4'h0, bms=2'b11; hc=1, vc=1.
- Blanking: pixel_rgb=18'h3FFFF during hcnt 640..799. Expect CE*=0 and *ms=0 while blank=1.
- Stall and mid-frame reset: hold pix_ce=0 for 50 clk at req_x=300 → all outputs and req_x stay frozen. Then pulse rst_n low at (300,200) → outputs go to reset values without waiting for a clk edge. After release, req_x=0 and req_y=0.
